// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_pkg;

    // Controller phases: wait for word count, stream words, settle, let the CPU run.
    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } boot_state_t;

    // Instruction memory depth in 32-bit words when not overridden.
    localparam int DEFAULT_MEM_SIZE = 256;

    // Instruction handed to the CPU whenever a real fetch is not allowed.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage : imem_pkg

// File: rtl/word_packer.sv
// Collects four loader bytes into one little-endian 32-bit word.
// The fourth byte is forwarded combinationally so the word is complete
// on the same edge that accepts it.
module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [1:0]      idx_q;
    logic [2:0][7:0] lane_q;

    // Byte position within the current word; wraps after the fourth byte.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            idx_q <= 2'd0;
        end else if (valid_i) begin
            idx_q <= idx_q + 2'd1;
        end
    end

    // One holding register per lower byte lane, loaded when its slot arrives.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (reset || clear_i) begin
                    lane_q[gi] <= 8'h00;
                end else if (valid_i && (idx_q == 2'(gi))) begin
                    lane_q[gi] <= byte_i;
                end
            end
        end
    endgenerate

    // Top byte comes straight from the input on the completing transfer.
    always_comb begin
        word_o      = {byte_i, lane_q[2], lane_q[1], lane_q[0]};
        word_done_o = valid_i && (idx_q == 2'd3);
    end

endmodule : word_packer

// File: rtl/imem_boot_ctrl.sv
// Boot controller: receives a byte-stream program (count byte followed by
// little-endian words), writes it into external instruction memory, then
// releases the CPU and gates instruction fetches by PC validity.
module imem_boot_ctrl
    import imem_pkg::*;
#(
    parameter int MEM_SIZE = DEFAULT_MEM_SIZE,
    parameter int ADDR_W   = $clog2(MEM_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              load_req,
    input  logic [31:0]       PC,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       instruction,
    output logic              cpu_run,
    output logic              fetch_err,
    output logic [ADDR_W:0]   loaded_words
);

    boot_state_t       state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;     // words expected in this load
    logic [ADDR_W:0]   widx_q, widx_d;       // index of word being assembled
    logic [ADDR_W:0]   loaded_q, loaded_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              pk_clear;
    logic              pk_valid;
    logic [31:0]       pk_word;
    logic              pk_done;
    logic [ADDR_W:0]   n_clip;

    word_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (pk_clear),
        .valid_i     (pk_valid),
        .byte_i      (rx_data),
        .word_o      (pk_word),
        .word_done_o (pk_done)
    );

    // State and write-port registers; reset drops any partial word and pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_HDR;
            count_q  <= '0;
            widx_q   <= '0;
            loaded_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            widx_q   <= widx_d;
            loaded_q <= loaded_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Next-state logic: header capture, word sequencing, flush and run/reload.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        widx_d   = widx_q;
        loaded_d = loaded_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        rx_ready = 1'b0;
        pk_valid = 1'b0;
        pk_clear = 1'b0;

        // A count larger than the memory can only be partly honoured.
        if ({24'd0, rx_data} > 32'(MEM_SIZE)) begin
            n_clip = (ADDR_W+1)'(MEM_SIZE);
        end else begin
            n_clip = (ADDR_W+1)'(rx_data);
        end

        case (state_q)
            ST_HDR: begin
                rx_ready = 1'b1;
                pk_clear = 1'b1;
                if (rx_valid) begin
                    count_d = n_clip;
                    widx_d  = '0;
                    if (n_clip == '0) begin
                        state_d  = ST_RUN;
                        loaded_d = '0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                rx_ready = 1'b1;
                pk_valid = rx_valid;
                if (pk_done) begin
                    we_d    = 1'b1;
                    waddr_d = widx_q[ADDR_W-1:0];
                    wdata_d = pk_word;
                    widx_d  = widx_q + (ADDR_W+1)'(1);
                    if (widx_q == count_q - (ADDR_W+1)'(1)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                state_d  = ST_RUN;
                loaded_d = count_q;
            end
            ST_RUN: begin
                if (load_req) begin
                    state_d = ST_HDR;
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    // Fetch path: word address from PC, NOP substituted unless the fetch is legal.
    always_comb begin
        cpu_run      = (state_q == ST_RUN);
        mem_raddr    = PC[ADDR_W+1:2];
        fetch_err    = cpu_run && ((PC[1:0] != 2'b00) || ((PC >> (ADDR_W + 2)) != 32'd0));
        instruction  = (cpu_run && !fetch_err) ? mem_rdata : NOP_INSTR;
        mem_we       = we_q;
        mem_waddr    = waddr_q;
        mem_wdata    = wdata_q;
        loaded_words = loaded_q;
    end

endmodule : imem_boot_ctrl

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with a behavioural instruction memory.
module tb_imem_boot_ctrl;

    localparam int MEM_SIZE = 256;
    localparam int ADDR_W   = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              load_req;
    logic [31:0]       PC;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic [31:0]       instruction;
    logic              cpu_run;
    logic              fetch_err;
    logic [ADDR_W:0]   loaded_words;

    logic [31:0] mem [MEM_SIZE];
    int          nwrites = 0;
    int          vectors = 0;
    int          miscompares = 0;

    imem_boot_ctrl #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .load_req     (load_req),
        .PC           (PC),
        .mem_rdata    (mem_rdata),
        .mem_raddr    (mem_raddr),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .instruction  (instruction),
        .cpu_run      (cpu_run),
        .fetch_err    (fetch_err),
        .loaded_words (loaded_words)
    );

    always #5 clk = ~clk;

    // Behavioural memory: synchronous write, combinational read.
    assign mem_rdata = mem[mem_raddr];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] = mem_wdata;
            nwrites++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one byte for a single cycle; returns at the negedge after the accepting edge.
    task automatic put(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Same, but preceded by a random idle gap with garbage on the data lines.
    task automatic put_gap(input logic [7:0] b);
        int g;
        g = $urandom_range(0, 3);
        for (int i = 0; i < g; i++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        put(b);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        load_req = 1'b0;
        PC       = 32'h0;
        tick(); tick();

        // Reset state
        chk("rst_cpu_run", 64'(cpu_run), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_waddr", 64'(mem_waddr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_loaded", 64'(loaded_words), 64'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", 64'(rx_ready), 64'd1);

        // Two-word load
        put(8'h02);
        chk("hdr_cpu_run", 64'(cpu_run), 64'd0);
        put(8'h01); put(8'h00); put(8'h11); put(8'h20);
        chk("w0_we", 64'(mem_we), 64'd1);
        chk("w0_addr", 64'(mem_waddr), 64'd0);
        chk("w0_data", 64'(mem_wdata), 64'h2011_0001);
        put(8'h00);
        chk("w1_nowe", 64'(mem_we), 64'd0);
        put(8'h00); put(8'h00); put(8'hAC);
        chk("w1_we", 64'(mem_we), 64'd1);
        chk("w1_addr", 64'(mem_waddr), 64'd1);
        chk("w1_data", 64'(mem_wdata), 64'hAC00_0000);
        chk("flush_ready", 64'(rx_ready), 64'd0);
        chk("flush_cpu_run", 64'(cpu_run), 64'd0);
        tick();
        chk("run_cpu_run", 64'(cpu_run), 64'd1);
        chk("run_loaded", 64'(loaded_words), 64'd2);
        chk("run_ready", 64'(rx_ready), 64'd0);
        chk("run_nowe", 64'(mem_we), 64'd0);
        chk("mem2_kept", 64'(mem[2]), 64'hDEAD_0002);

        // Fetch path
        PC = 32'd8; #1;
        chk("pc8_raddr", 64'(mem_raddr), 64'd2);
        chk("pc8_instr", 64'(instruction), 64'hDEAD_0002);
        chk("pc8_err", 64'(fetch_err), 64'd0);
        PC = 32'd0; #1;
        chk("pc0_instr", 64'(instruction), 64'h2011_0001);
        PC = 32'd6; #1;
        chk("pc6_err", 64'(fetch_err), 64'd1);
        chk("pc6_instr", 64'(instruction), 64'd0);
        PC = 32'h400; #1;
        chk("pc400_err", 64'(fetch_err), 64'd1);
        chk("pc400_instr", 64'(instruction), 64'd0);
        PC = 32'h3FC; #1;
        chk("pc3fc_err", 64'(fetch_err), 64'd0);
        PC = 32'd0;

        // Bytes offered while running are ignored
        w0 = nwrites;
        put(8'h55); put(8'h66); put(8'h77); put(8'h88); tick();
        chk("run_ignore_rx", 64'(nwrites - w0), 64'd0);
        chk("run_still", 64'(cpu_run), 64'd1);

        // Reload via load_req; load_req held through header and first bytes is ignored
        load_req = 1'b1;
        tick();
        chk("reload_cpu_run", 64'(cpu_run), 64'd0);
        chk("reload_ready", 64'(rx_ready), 64'd1);
        chk("reload_instr", 64'(instruction), 64'd0);
        put(8'h01); put(8'h78); put(8'h56);
        load_req = 1'b0;
        put(8'h34); put(8'h12);
        chk("reload_addr", 64'(mem_waddr), 64'd0);
        chk("reload_data", 64'(mem_wdata), 64'h1234_5678);
        tick();
        chk("reload_loaded", 64'(loaded_words), 64'd1);
        chk("reload_mem0", 64'(mem[0]), 64'h1234_5678);
        chk("reload_mem1", 64'(mem[1]), 64'hAC00_0000);

        // Zero-length load
        load_req = 1'b1; tick(); load_req = 1'b0;
        w0 = nwrites;
        put(8'h00);
        chk("zero_cpu_run", 64'(cpu_run), 64'd1);
        chk("zero_loaded", 64'(loaded_words), 64'd0);
        chk("zero_nowrite", 64'(nwrites - w0), 64'd0);

        // Reset in the middle of word 1
        load_req = 1'b1; tick(); load_req = 1'b0;
        w0 = nwrites;
        put(8'h03);
        put(8'hAA); put(8'hBB); put(8'hCC); put(8'hDD);
        put(8'h11); put(8'h22);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_we", 64'(mem_we), 64'd0);
        tick();
        chk("mid_rst_we2", 64'(mem_we), 64'd0);
        chk("mid_rst_ready", 64'(rx_ready), 64'd1);
        chk("mid_rst_cpu_run", 64'(cpu_run), 64'd0);
        chk("mid_rst_writes", 64'(nwrites - w0), 64'd1);
        chk("mid_rst_mem0", 64'(mem[0]), 64'hDDCC_BBAA);
        chk("mid_rst_mem1", 64'(mem[1]), 64'hAC00_0000);
        put(8'h01); put(8'h01); put(8'h02); put(8'h03); put(8'h04);
        chk("restart_addr", 64'(mem_waddr), 64'd0);
        chk("restart_data", 64'(mem_wdata), 64'h0403_0201);
        tick();
        chk("restart_run", 64'(cpu_run), 64'd1);

        // Three-word load with random gaps in rx_valid
        load_req = 1'b1; tick(); load_req = 1'b0;
        put_gap(8'h03);
        for (int i = 0; i < 12; i++) put_gap(8'(8'h10 + i));
        tick();
        chk("gap_run", 64'(cpu_run), 64'd1);
        chk("gap_loaded", 64'(loaded_words), 64'd3);
        chk("gap_mem0", 64'(mem[0]), 64'h1312_1110);
        chk("gap_mem1", 64'(mem[1]), 64'h1716_1514);
        chk("gap_mem2", 64'(mem[2]), 64'h1B1A_1918);
        chk("gap_mem3", 64'(mem[3]), 64'hDEAD_0003);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_imem_boot_ctrl
